// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data RAM with memory-mapped TX byte FIFO and cycle counter; DATA_MEM_MMIO_CYCLE_COUNTER_EN enables the counter
module data_mem_mmio #(
    parameter int RAM_WORDS = 64,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    // RAM words start at zero and are never touched by reset
    logic [31:0] mem [RAM_WORDS] = '{default: '0};
    logic [7:0]  fifo_q [TX_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [31:0]   cycle_val, load_val;
    logic          sel_ram, sel_txd, sel_sts, sel_cyc;
    logic          full, empty, accept, push, pop, ram_we;
    logic          unused_addr;

    assign unused_addr = ^req_addr[1:0];

`ifdef DATA_MEM_MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    // free-running counter, wraps naturally at 2^32
    always_comb cycle_d = cycle_q + 32'd1;

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // decode, handshake, FIFO bookkeeping and load response
    always_comb begin
        sel_ram = req_addr[31:8] == 24'h0;
        sel_txd = req_addr[31:2] == 30'h40;
        sel_sts = req_addr[31:2] == 30'h41;
        sel_cyc = req_addr[31:2] == 30'h42;
        full = count_q == CW'(TX_DEPTH);
        empty = count_q == '0;
        req_ready = !(req_valid && req_we && sel_txd && full);
        accept = req_valid && req_ready && !rst;
        push = accept && req_we && sel_txd;
        ram_we = accept && req_we && sel_ram;
        pop = tx_valid_q && tx_ready;
        load_val = sel_ram ? mem[req_addr[AW+1:2]] :
                   sel_sts ? {27'b0, 3'(count_q), full, empty} :
                   sel_cyc ? cycle_val : 32'h0;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        tx_valid_d = count_d != '0;
        // the new head may be the byte being pushed this edge (empty, or last entry popping)
        tx_data_d = (push && wr_ptr_q == rd_ptr_d) ? req_wdata[7:0] : fifo_q[rd_ptr_d];
        rdata_valid_d = accept && !req_we;
        rdata_d = rdata_valid_d ? load_val : rdata_q;
    end

    // storage writes: RAM and FIFO slots carry no reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[req_addr[AW+1:2]] <= req_wdata;
        if (push) fifo_q[wr_ptr_q] <= req_wdata[7:0];
    end

    // control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            rdata_q <= '0;
            rdata_valid_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign rdata = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign tx_valid = tx_valid_q;
    assign tx_data = tx_data_q;
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed vector table, reset corner cases and randomized traffic against a queue-based model
module tb_data_mem_mmio;
    localparam int TXD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] m_ram [64];
    logic [7:0]  mq [$];
    logic [31:0] m_rd;
    logic        m_rv;
    logic [31:0] m_cycle;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        txr;
        logic        e_ready;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_tv;
        logic [7:0]  e_td;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    data_mem_mmio dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        int n = mq.size();
        if (a < 32'h100) return m_ram[a[7:2]];
        if (a == 32'h104) return {27'b0, n[2:0], n == TXD, n == 0};
`ifdef DATA_MEM_MMIO_CYCLE_COUNTER_EN
        if (a == 32'h108) return m_cycle;
`endif
        return 32'h0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_rd = '0;
        m_rv = 1'b0;
        m_cycle = '0;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic txr);
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        tx_ready = txr;
    endtask

    // one clock: model advances from the inputs held across the edge
    task automatic tick(input bit chk);
        logic [31:0] a, lv;
        bit rdy, acc, pp;
        #1;
        a = req_addr & ~32'h3;
        rdy = !(req_valid && req_we && a == 32'h100 && mq.size() == TXD);
        if (chk) check("req_ready", {31'b0, req_ready}, {31'b0, rdy});
        acc = req_valid && rdy;
        pp = tx_ready && mq.size() != 0;
        lv = model_load(a);
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (acc && req_we && a < 32'h100) m_ram[a[7:2]] = req_wdata;
        if (acc && req_we && a == 32'h100) mq.push_back(req_wdata[7:0]);
        m_rv = acc && !req_we;
        if (m_rv) m_rd = lv;
        m_cycle = m_cycle + 32'd1;
        #1;
        if (chk) begin
            check("rdata_valid", {31'b0, rdata_valid}, {31'b0, m_rv});
            check("rdata", rdata, m_rd);
            check("tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, mq[0]});
        end
    endtask

    task automatic do_reset();
        set_req(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] addrs [8];
        logic [31:0] exp39;
        tbl[0]  = '{1, 1, 32'h004, 32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 8'h00};
        tbl[1]  = '{1, 0, 32'h004, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 8'h00};
        tbl[2]  = '{0, 0, 32'h000, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0, 8'h00};
        tbl[3]  = '{1, 1, 32'h100, 32'h41,       0, 1, 0, 32'hDEADBEEF, 1, 8'h41};
        tbl[4]  = '{1, 1, 32'h100, 32'h42,       0, 1, 0, 32'hDEADBEEF, 1, 8'h41};
        tbl[5]  = '{1, 1, 32'h100, 32'h43,       0, 1, 0, 32'hDEADBEEF, 1, 8'h41};
        tbl[6]  = '{1, 1, 32'h100, 32'h44,       0, 1, 0, 32'hDEADBEEF, 1, 8'h41};
        tbl[7]  = '{1, 1, 32'h100, 32'h45,       0, 0, 0, 32'hDEADBEEF, 1, 8'h41};
        tbl[8]  = '{1, 0, 32'h104, 32'h0,        0, 1, 1, 32'h12,       1, 8'h41};
        tbl[9]  = '{0, 0, 32'h000, 32'h0,        1, 1, 0, 32'h12,       1, 8'h42};
        tbl[10] = '{0, 0, 32'h000, 32'h0,        1, 1, 0, 32'h12,       1, 8'h43};
        tbl[11] = '{0, 0, 32'h000, 32'h0,        1, 1, 0, 32'h12,       1, 8'h44};
        tbl[12] = '{0, 0, 32'h000, 32'h0,        1, 1, 0, 32'h12,       0, 8'h00};
        tbl[13] = '{1, 0, 32'h104, 32'h0,        0, 1, 1, 32'h01,       0, 8'h00};
        tbl[14] = '{1, 1, 32'h100, 32'h55,       0, 1, 0, 32'h01,       1, 8'h55};
        tbl[15] = '{1, 1, 32'h100, 32'h66,       1, 1, 0, 32'h01,       1, 8'h66};
        tbl[16] = '{1, 0, 32'h104, 32'h0,        0, 1, 1, 32'h04,       1, 8'h66};
        tbl[17] = '{1, 0, 32'h10C, 32'h0,        1, 1, 1, 32'h0,        0, 8'h00};
        tbl[18] = '{1, 1, 32'h108, 32'h12345678, 0, 1, 0, 32'h0,        0, 8'h00};
        tbl[19] = '{1, 0, 32'h007, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 8'h00};
        tbl[20] = '{1, 0, 32'h100, 32'h0,        0, 1, 1, 32'h0,        0, 8'h00};
        addrs = '{32'h000, 32'h004, 32'h0FC, 32'h100, 32'h104, 32'h108, 32'h10C, 32'hFFFF0100};
        for (int i = 0; i < 64; i++) m_ram[i] = '0;
        model_clear();

        do_reset();
        for (int i = 0; i < NV; i++) begin
            set_req(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].txr);
            #1;
            check($sformatf("vec%0d_ready", i), {31'b0, req_ready}, {31'b0, tbl[i].e_ready});
            tick(0);
            check($sformatf("vec%0d_rv", i), {31'b0, rdata_valid}, {31'b0, tbl[i].e_rv});
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rd);
            check($sformatf("vec%0d_tv", i), {31'b0, tx_valid}, {31'b0, tbl[i].e_tv});
            if (tbl[i].e_tv) check($sformatf("vec%0d_td", i), {24'b0, tx_data}, {24'b0, tbl[i].e_td});
        end

        // cycle counter read at the 10th edge after reset release
        do_reset();
        for (int i = 0; i < 9; i++) tick(1);
        set_req(1, 0, 32'h108, 0, 0);
        tick(1);
`ifdef DATA_MEM_MMIO_CYCLE_COUNTER_EN
        exp39 = 32'd9;
`else
        exp39 = 32'd0;
`endif
        check("cycle_at_10", rdata, exp39);

        // reset mid-operation with two queued bytes and a fresh load response
        set_req(1, 1, 32'h100, 32'hA1, 0);
        tick(1);
        set_req(1, 1, 32'h100, 32'hA2, 0);
        tick(1);
        set_req(1, 0, 32'h004, 0, 0);
        tick(1);
        set_req(0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        set_req(1, 0, 32'h004, 0, 0);
        @(posedge clk);
        #1;
        check("rst_hold_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        check("rst_hold_rdata", rdata, 32'h0);
        set_req(0, 0, 0, 0, 0);
        rst = 1'b0;
        model_clear();
        tick(1);
        tick(1);
        set_req(1, 0, 32'h004, 0, 0);
        tick(1);
        check("ram_survives_rst", rdata, 32'hDEADBEEF);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(3) != 0, $urandom_range(1) == 1,
                    addrs[$urandom_range(7)] | 32'($urandom_range(3)),
                    $urandom, $urandom_range(2) == 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64: number of 32-bit data RAM words (power of two, max 64).
REQ-002 SHALL have parameter TX_DEPTH, default 4: number of TX FIFO entries (power of two).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: CPU access request present.
REQ-006 SHALL have port req_ready, output, 1: request can be accepted this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address; bits [1:0] ignored.
REQ-009 SHALL have port req_wdata, input, 32: store data.
REQ-010 SHALL have port rdata, output, 32: load response data.
REQ-011 SHALL have port rdata_valid, output, 1: rdata carries a new load response.
REQ-012 SHALL have port tx_data, output, 8: TX FIFO head byte.
REQ-013 SHALL have port tx_valid, output, 1: TX FIFO non-empty.
REQ-014 SHALL have port tx_ready, input, 1: consumer accepts tx_data.

Function
REQ-015 An accepted request SHALL be defined as req_valid & req_ready sampled at a posedge.
REQ-016 Address map SHALL be: 0x000-0x0FF RAM (word index addr[7:2] mod RAM_WORDS); 0x100 TX_DATA; 0x104 TX_STATUS; 0x108 CYCLE; all other addresses unmapped.
REQ-017 req_ready SHALL be 0 only when req_valid & req_we, addr selects TX_DATA, and the FIFO is full; otherwise it SHALL be 1. A pop in the same cycle SHALL NOT raise req_ready.
REQ-018 An accepted RAM store SHALL write req_wdata to the addressed word at that edge.
REQ-019 An accepted TX_DATA store SHALL push req_wdata[7:0] at that edge. Stores to TX_STATUS, CYCLE, and unmapped addresses SHALL be ignored.
REQ-020 An accepted load SHALL update rdata and pulse rdata_valid for exactly one cycle at the following edge (latency 1 cycle).
REQ-021 rdata SHALL hold its value until the next accepted load.
REQ-022 Load return values:
- RAM: word contents.
- TX_DATA: 0.
- TX_STATUS: {27'b0, count[2:0], full, empty}.
- CYCLE: counter value.
- Unmapped: 0.
REQ-023 TX_STATUS and CYCLE loads SHALL return values sampled before any push, pop, or increment at the accepting edge.
REQ-024 A pop SHALL occur at the edge where tx_valid & tx_ready.
REQ-025 tx_valid SHALL equal not-empty, and tx_data SHALL equal the head entry; both SHALL be registered with no write-to-output bypass.
REQ-026 A push into an empty FIFO SHALL raise tx_valid on the cycle after the push edge.
REQ-027 On a simultaneous push and pop with the FIFO neither empty nor full, both SHALL occur and count SHALL be unchanged.
REQ-028 Read/write pointers SHALL wrap modulo TX_DEPTH, and count SHALL range 0..TX_DEPTH.
REQ-029 The cycle counter SHALL be 32-bit, increment every cycle, and wrap from 0xFFFFFFFF to 0.
REQ-030 RAM contents SHALL initialise to 0 at time zero in simulation and SHALL NOT be affected by rst.

Reset
REQ-031 While rst is high, the following SHALL be 0: rdata, rdata_valid, tx_valid, tx_data, FIFO pointers, count, and cycle counter.
REQ-032 Asserting rst mid-operation SHALL discard FIFO entries and drop any pending load response (no rdata_valid pulse after reset).
REQ-033 No request SHALL be accepted on an edge at which rst is high.

Configuration
REQ-034 Macro DATA_MEM_MMIO_CYCLE_COUNTER_EN SHALL control the cycle counter.
- Defined: the counter is present and CYCLE reads return it.
- Undefined: no counter register exists, and CYCLE reads return 0 like unmapped addresses.

Verification
REQ-035 Store 0xDEADBEEF to 0x04, then load 0x04: rdata = 0xDEADBEEF with rdata_valid high exactly 1 cycle after the load is accepted.
REQ-036 With tx_ready=0, store 0x41,0x42,0x43,0x44 to 0x100, then attempt a 5th store:
- req_ready = 0 on the 5th store.
- TX_STATUS load returns 0x12.
REQ-037 From REQ-036's state, raise tx_ready for 4 cycles:
- tx_data sequence is 0x41,0x42,0x43,0x44.
- Then tx_valid = 0, and TX_STATUS returns 0x01.
REQ-038 Push one byte, and on the next cycle push while popping: count stays 1, and the byte order is preserved.
REQ-039 Release rst, then load 0x108 at the 10th post-reset edge: rdata = 9 with the macro defined, or 0 without it.
REQ-040 Assert rst with 2 FIFO entries and a load in flight: tx_valid = 0 and rdata_valid = 0 immediately, and they remain 0 after release.
